aa_frame_sched: RTL and testbench
=================================

Name: aa_frame_sched

Overview:
- Sequencer for the anti-aliasing stencil datapath. It scans a SIZE x SIZE frame held in a 1-read-port frame RAM in row-major order.
- For each interior pixel it fetches the 5-point stencil (centre, N, S, W, E) and hands it to the AA datapath with a valid/ready handshake. It waits for the datapath result and writes it to the output frame buffer.
- Border pixels bypass the datapath and are copied unchanged.
- It latches the threshold configuration per frame and signals frame completion.

Parameters:
- SIZE, 64, frame width and height in pixels; must be at least 3.
- PIX_W, 8, pixel width in bits.
- ADDR_W, $clog2(SIZE*SIZE), pixel address width.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  frame start request; sampled only in IDLE
- th  in  PIX_W  threshold; latched when start is accepted
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the final write
- rd_en  out  1  frame RAM read strobe
- rd_addr  out  ADDR_W  read address, row*SIZE+col
- rd_data  in  PIX_W  read data, valid the cycle after rd_en
- st_valid  out  1  stencil valid to datapath
- st_ready  in  1  datapath accepts stencil
- st_c, st_n, st_s, st_w, st_e  out  PIX_W each  stencil pixels
- st_th  out  PIX_W  latched threshold
- res_valid  in  1  datapath result valid
- res_data  in  PIX_W  datapath result
- wr_en  out  1  output buffer write strobe
- wr_addr  out  ADDR_W  write address, equal to the current pixel address
- wr_data  out  PIX_W  write data

Behaviour:
- Reset (reset_n=0 at a clk edge) puts the block in IDLE.
  - Outputs clear to 0: busy, done, rd_en, st_valid, wr_en, all addresses, stencil registers and st_th.
  - Reset mid-frame abandons the frame: no further reads or writes, and no done pulse.
- Interior pixel: 1 <= row <= SIZE-2 and 1 <= col <= SIZE-2. Every other pixel is a border pixel.
- States:
  - IDLE: start=1 latches th into st_th, clears row and col to 0, sets busy, then goes to FETCH. start while busy is ignored.
  - FETCH: issues one read per cycle, rd_en=1.
    - Interior pixel: 5 cycles, in order C, N(row-1), S(row+1), W(col-1), E(col+1).
    - Border pixel: 1 cycle, C only.
    - Each rd_data is captured into its stencil register the cycle after its read.
    - Then goes to FWAIT.
  - FWAIT: 1 cycle, rd_en=0. Captures the last read.
    - Border pixel: goes to WRITE with wr_data=C.
    - Interior pixel: goes to ISSUE.
  - ISSUE: holds st_valid=1 with stable stencil values until st_ready=1, then goes to WAIT_RES. st_valid drops the cycle after the handshake.
  - WAIT_RES: stays until res_valid=1, then captures res_data and goes to WRITE. res_valid seen outside WAIT_RES is ignored.
  - WRITE: 1 cycle, wr_en=1, wr_addr = current pixel address. The next pixel is computed in the same cycle: col+1, wrapping to 0 with row+1 at col=SIZE-1.
    - Last pixel (SIZE-1, SIZE-1): goes to DONE.
    - Otherwise: goes to FETCH.
  - DONE: 1 cycle with done=1 and busy=0, then goes to IDLE. start in DONE is ignored; start is accepted from the next IDLE cycle.
- Cycle costs, with start accepted at cycle T and the first rd_en at T+1:
  - Border pixel: 3 cycles.
  - Interior pixel: 9 cycles minimum (5 FETCH, 1 FWAIT, ISSUE 1, WAIT_RES 1, WRITE 1), with st_ready=1 and res_valid arriving the cycle after the handshake.
- Only one stencil is ever outstanding.
- The output buffer is separate from the frame RAM, so there is no read-after-write hazard.
- Address arithmetic is unsigned ADDR_W and never wraps for legal row/col values.

Decomposition:
- Package aa_pkg holds:
  - the state enum aa_sched_state_t (IDLE, FETCH, FWAIT, ISSUE, WAIT_RES, WRITE, DONE);
  - the stencil index enum (C, N, S, W, E);
  - the SIZE, PIX_W and ADDR_W defaults.
- One sub-module, aa_scan_cnt, holds the row/col counters. It has advance and clear inputs and outputs row, col, is_border, is_last and pixel address.

Test Plan:
- SIZE=4, RAM pixel = address (0..15), datapath model with st_ready=1 and res = C+1 one cycle after the handshake, start at T. Required: 16 writes; border addresses write the address value, interior addresses 5, 6, 9, 10 write 6, 7, 10, 11; last wr_en at T+72; done pulse at T+73; busy high T+1..T+72.
- Interior pixel (1,1) of the same frame. Required: reads at addresses 5, 1, 9, 4, 6 in consecutive cycles; st_c/n/s/w/e = 5/1/9/4/6 while st_valid=1.
- Hold st_ready=0 for 4 cycles on the first stencil. Required: st_valid stays high with stable stencil values, no read or write is issued, and completion slips 4 cycles (done at T+77).
- Delay res_valid by 3 extra cycles. Required: no write until res_valid; a spurious res_valid pulsed during FETCH is ignored.
- th=0x80 at start, then th changed mid-frame and start pulsed while busy. Required: st_th stays 0x80 and the frame is not restarted.
- Reset (reset_n=0) at T+20. Required: all outputs 0 the next cycle, no done pulse. A fresh start then completes in 72 cycles.

Source files
------------

// File: rtl/aa_pkg.sv
// Shared types and defaults for the anti-aliasing frame sequencer.
// Imported by the scheduler top and its scan counter.
package aa_pkg;

  localparam int AA_SIZE   = 64;
  localparam int AA_PIX_W  = 8;
  localparam int AA_ADDR_W = $clog2(AA_SIZE * AA_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    FWAIT,
    ISSUE,
    WAIT_RES,
    WRITE,
    DONE
  } aa_sched_state_t;

  typedef enum logic [2:0] {
    SI_C,
    SI_N,
    SI_S,
    SI_W,
    SI_E
  } aa_st_idx_t;

  function automatic aa_st_idx_t aa_next_idx(input aa_st_idx_t i);
    aa_st_idx_t n;
    n = SI_C;
    case (i)
      SI_C:    n = SI_N;
      SI_N:    n = SI_S;
      SI_S:    n = SI_W;
      SI_W:    n = SI_E;
      default: n = SI_C;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/aa_frame_sched_scan.sv
// Row-major row/col scan counter for the frame sequencer.
// Wraps to (0,0) after the last pixel.
module aa_scan_cnt
  import aa_pkg::*;
#(
  parameter int SIZE   = AA_SIZE,
  parameter int ADDR_W = AA_ADDR_W,
  parameter int RC_W   = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic              i_advance,
  output logic [RC_W-1:0]   o_row,
  output logic [RC_W-1:0]   o_col,
  output logic              o_is_border,
  output logic              o_is_last,
  output logic [ADDR_W-1:0] o_addr
);

  localparam logic [RC_W-1:0]   L_MAX  = RC_W'(SIZE - 1);
  localparam logic [ADDR_W-1:0] L_SIZE = ADDR_W'(SIZE);

  logic [RC_W-1:0] r_row;
  logic [RC_W-1:0] r_col;

  always_ff @(posedge clk) begin
    if (!reset_n || i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_advance) begin
      if (r_col == L_MAX) begin
        r_col <= '0;
        r_row <= (r_row == L_MAX) ? '0 : r_row + RC_W'(1);
      end else begin
        r_col <= r_col + RC_W'(1);
      end
    end
  end

  assign o_row       = r_row;
  assign o_col       = r_col;
  assign o_is_border = (r_row == '0) || (r_row == L_MAX) ||
                       (r_col == '0) || (r_col == L_MAX);
  assign o_is_last   = (r_row == L_MAX) && (r_col == L_MAX);
  assign o_addr      = ADDR_W'(r_row) * L_SIZE + ADDR_W'(r_col);

endmodule

// File: rtl/aa_frame_sched.sv
// Frame sequencer: fetches 5-point stencils, hands them to the AA
// datapath and writes results; border pixels are copied through.
module aa_frame_sched
  import aa_pkg::*;
#(
  parameter int SIZE   = AA_SIZE,
  parameter int PIX_W  = AA_PIX_W,
  parameter int ADDR_W = $clog2(SIZE * SIZE)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [PIX_W-1:0]  th,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic [PIX_W-1:0]  st_c,
  output logic [PIX_W-1:0]  st_n,
  output logic [PIX_W-1:0]  st_s,
  output logic [PIX_W-1:0]  st_w,
  output logic [PIX_W-1:0]  st_e,
  output logic [PIX_W-1:0]  st_th,
  input  logic              res_valid,
  input  logic [PIX_W-1:0]  res_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data
);

  localparam int                RC_W   = $clog2(SIZE);
  localparam logic [ADDR_W-1:0] L_SIZE = ADDR_W'(SIZE);

  aa_sched_state_t r_state;
  aa_sched_state_t w_nxt;
  aa_st_idx_t      r_idx;
  aa_st_idx_t      r_cap_idx;
  logic            r_cap_v;

  logic [PIX_W-1:0] r_c;
  logic [PIX_W-1:0] r_n;
  logic [PIX_W-1:0] r_s;
  logic [PIX_W-1:0] r_w;
  logic [PIX_W-1:0] r_e;
  logic [PIX_W-1:0] r_th;
  logic [PIX_W-1:0] r_res;

  logic [RC_W-1:0]   w_row;
  logic [RC_W-1:0]   w_col;
  logic [RC_W-1:0]   w_rr;
  logic [RC_W-1:0]   w_rc;
  logic [ADDR_W-1:0] w_pix;
  logic              w_border;
  logic              w_last;
  logic              w_clr;
  logic              w_adv;
  logic              w_rd_en;
  logic              w_wr_en;
  logic              w_st_valid;
  logic              w_busy;
  logic              w_done;

  aa_scan_cnt #(
    .SIZE   (SIZE),
    .ADDR_W (ADDR_W),
    .RC_W   (RC_W)
  ) u_scan (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_clear     (w_clr),
    .i_advance   (w_adv),
    .o_row       (w_row),
    .o_col       (w_col),
    .o_is_border (w_border),
    .o_is_last   (w_last),
    .o_addr      (w_pix)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt      = r_state;
    w_rd_en    = 1'b0;
    w_wr_en    = 1'b0;
    w_st_valid = 1'b0;
    w_busy     = 1'b1;
    w_done     = 1'b0;
    w_clr      = 1'b0;
    w_adv      = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          w_clr = 1'b1;
          w_nxt = FETCH;
        end
      end
      FETCH: begin
        w_rd_en = 1'b1;
        if (w_border || r_idx == SI_E) w_nxt = FWAIT;
      end
      FWAIT: w_nxt = w_border ? WRITE : ISSUE;
      ISSUE: begin
        w_st_valid = 1'b1;
        if (st_ready) w_nxt = WAIT_RES;
      end
      WAIT_RES: if (res_valid) w_nxt = WRITE;
      WRITE: begin
        w_wr_en = 1'b1;
        w_adv   = 1'b1;
        w_nxt   = w_last ? DONE : FETCH;
      end
      DONE: begin
        w_busy = 1'b0;
        w_done = 1'b1;
        w_nxt  = IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_nxt  = IDLE;
      end
    endcase
  end

  // Neighbour coordinates for the stencil element being fetched
  always_comb begin
    w_rr = w_row;
    w_rc = w_col;
    case (r_idx)
      SI_N:    w_rr = w_row - RC_W'(1);
      SI_S:    w_rr = w_row + RC_W'(1);
      SI_W:    w_rc = w_col - RC_W'(1);
      SI_E:    w_rc = w_col + RC_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_idx     <= SI_C;
      r_cap_idx <= SI_C;
      r_cap_v   <= 1'b0;
      r_c       <= '0;
      r_n       <= '0;
      r_s       <= '0;
      r_w       <= '0;
      r_e       <= '0;
      r_th      <= '0;
      r_res     <= '0;
    end else begin
      r_cap_v   <= w_rd_en;
      r_cap_idx <= r_idx;
      r_idx     <= (r_state == FETCH) ? aa_next_idx(r_idx) : SI_C;
      if (r_state == IDLE && start) r_th <= th;
      if (r_cap_v) begin
        case (r_cap_idx)
          SI_C:    r_c <= rd_data;
          SI_N:    r_n <= rd_data;
          SI_S:    r_s <= rd_data;
          SI_W:    r_w <= rd_data;
          SI_E:    r_e <= rd_data;
          default: ;
        endcase
      end
      if (r_state == WAIT_RES && res_valid) r_res <= res_data;
    end
  end

  assign busy     = w_busy;
  assign done     = w_done;
  assign rd_en    = w_rd_en;
  assign rd_addr  = w_rd_en ?
                    ADDR_W'(w_rr) * L_SIZE + ADDR_W'(w_rc) : '0;
  assign st_valid = w_st_valid;
  assign st_c     = r_c;
  assign st_n     = r_n;
  assign st_s     = r_s;
  assign st_w     = r_w;
  assign st_e     = r_e;
  assign st_th    = r_th;
  assign wr_en    = w_wr_en;
  assign wr_addr  = w_wr_en ? w_pix : '0;
  assign wr_data  = w_wr_en ? (w_border ? r_c : r_res) : '0;

endmodule

// File: tb/tb_aa_frame_sched.sv
// Self-checking bench for aa_frame_sched at SIZE=4.
// Table of frame configs plus a mid-frame reset sequence.
module tb_aa_frame_sched;

  localparam int SZ = 4;
  localparam int PW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] th = '0;
  logic          busy, done, rd_en, st_valid, st_ready, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [PW-1:0] rd_data;
  logic [PW-1:0] st_c, st_n, st_s, st_w, st_e, st_th;
  logic          res_valid;
  logic [PW-1:0] res_data;
  logic [PW-1:0] wr_data;

  aa_frame_sched #(.SIZE(SZ), .PIX_W(PW), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .th(th),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .st_valid(st_valid), .st_ready(st_ready),
    .st_c(st_c), .st_n(st_n), .st_s(st_s), .st_w(st_w), .st_e(st_e),
    .st_th(st_th), .res_valid(res_valid), .res_data(res_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame RAM: pixel value equals its address
  always @(posedge clk) if (rd_en) rd_data <= {4'h0, rd_addr};

  // Datapath model: res = C+1, res_dly extra cycles after handshake
  int            stall_cfg = 0;
  int            res_dly = 0;
  int            sv_cnt = 0;
  logic          res_spur = 1'b0;
  logic          m_valid = 1'b0;
  logic          m_pend = 1'b0;
  int            m_cnt = 0;
  logic [PW-1:0] m_data = '0;

  assign st_ready  = (sv_cnt >= stall_cfg);
  assign res_valid = m_valid | res_spur;

  always @(posedge clk) begin
    if (start) sv_cnt <= 0;
    else if (st_valid) sv_cnt <= sv_cnt + 1;
  end

  always @(posedge clk) begin
    m_valid <= 1'b0;
    if (st_valid && st_ready) begin
      if (res_dly == 0) begin
        m_valid  <= 1'b1;
        res_data <= st_c + 8'd1;
      end else begin
        m_pend <= 1'b1;
        m_cnt  <= res_dly - 1;
        m_data <= st_c + 8'd1;
      end
    end else if (m_pend) begin
      if (m_cnt == 0) begin
        m_valid  <= 1'b1;
        res_data <= m_data;
        m_pend   <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [PW-1:0] d;
  } wr_exp_t;

  typedef struct {
    int            stall;
    int            dly;
    logic [PW-1:0] th;
    bit            poke;
    bit            spur;
    int            exp_done;
  } vec_t;

  logic [AW-1:0] rdq[$];
  wr_exp_t       wrq[$];
  logic [PW-1:0] cq[$];

  int            nchk = 0;
  int            nerr = 0;
  int            done_cnt, done_cyc, last_wr, busy_cnt, first_busy;
  logic [PW-1:0] exp_th;
  bit            prev_sv = 1'b0;
  logic [39:0]   prev_st = '0;

  task automatic chk(input string nm, input longint got, input longint exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic push_frame();
    int a;
    rdq.delete(); wrq.delete(); cq.delete();
    for (int r = 0; r < SZ; r++) begin
      for (int c = 0; c < SZ; c++) begin
        a = r * SZ + c;
        if (r >= 1 && r <= SZ - 2 && c >= 1 && c <= SZ - 2) begin
          rdq.push_back(AW'(a));
          rdq.push_back(AW'(a - SZ));
          rdq.push_back(AW'(a + SZ));
          rdq.push_back(AW'(a - 1));
          rdq.push_back(AW'(a + 1));
          wrq.push_back('{a: AW'(a), d: PW'(a + 1)});
          cq.push_back(PW'(a));
        end else begin
          rdq.push_back(AW'(a));
          wrq.push_back('{a: AW'(a), d: PW'(a)});
        end
      end
    end
  endtask

  task automatic monitor();
    logic [PW-1:0] c;
    wr_exp_t       w;
    if (rd_en) begin
      if (rdq.size() == 0) chk("rd_extra", {1'b1, rd_addr}, 0);
      else chk("rd_addr", rd_addr, rdq.pop_front());
    end
    if (wr_en) begin
      last_wr = cyc;
      if (wrq.size() == 0) begin
        chk("wr_extra", {1'b1, wr_addr}, 0);
      end else begin
        w = wrq.pop_front();
        chk("wr_addr", wr_addr, w.a);
        chk("wr_data", wr_data, w.d);
      end
    end
    if (st_valid) begin
      chk("st_quiet", {rd_en, wr_en}, 0);
      chk("st_th", st_th, exp_th);
      if (prev_sv) chk("st_hold", {st_c, st_n, st_s, st_w, st_e}, prev_st);
      if (st_ready) begin
        if (cq.size() == 0) begin
          chk("st_extra", 1, 0);
        end else begin
          c = cq.pop_front();
          chk("stencil", {st_c, st_n, st_s, st_w, st_e},
              {c, c - 8'd4, c + 8'd4, c - 8'd1, c + 8'd1});
        end
      end
    end
    prev_sv = st_valid && !st_ready;
    prev_st = {st_c, st_n, st_s, st_w, st_e};
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) begin
      if (busy_cnt == 0) first_busy = cyc;
      busy_cnt++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v);
    int  t0;
    bit  sp_done;
    sp_done = 1'b0;
    push_frame();
    stall_cfg = v.stall;
    res_dly   = v.dly;
    exp_th    = v.th;
    th        = v.th;
    done_cnt  = 0;
    busy_cnt  = 0;
    last_wr   = 0;
    done_cyc  = 0;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    for (int k = 0; k < 400 && done_cnt == 0; k++) begin
      if (v.poke && k == 10) begin
        th    = 8'h33;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (v.spur && !sp_done && rd_en && cyc - t0 >= 16) begin
        res_spur = 1'b1;
        sp_done  = 1'b1;
      end else begin
        res_spur = 1'b0;
      end
      tick();
    end
    start    = 1'b0;
    res_spur = 1'b0;
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    tick();
    tick();
    chk("done_cnt", done_cnt, 1);
    chk("done_at", done_cyc - t0, v.exp_done);
    chk("last_wr_at", last_wr - t0, v.exp_done - 1);
    chk("busy_first", first_busy - t0, 1);
    chk("busy_len", busy_cnt, v.exp_done - 1);
    chk("wr_left", wrq.size(), 0);
    chk("rd_left", rdq.size(), 0);
    chk("st_left", cq.size(), 0);
  endtask

  vec_t tbl[4];

  initial begin
    int t0;
    tbl[0] = '{stall: 0, dly: 0, th: 8'h80, poke: 1, spur: 0, exp_done: 73};
    tbl[1] = '{stall: 4, dly: 0, th: 8'h11, poke: 0, spur: 0, exp_done: 77};
    tbl[2] = '{stall: 0, dly: 3, th: 8'h22, poke: 0, spur: 1, exp_done: 85};
    tbl[3] = '{stall: 2, dly: 1, th: 8'hff, poke: 0, spur: 0, exp_done: 79};
    exp_th = '0;

    reset_n = 1'b0;
    tick();
    tick();
    chk("reset_ctl", {busy, done, rd_en, st_valid, wr_en}, 0);
    chk("reset_addr", {rd_addr, wr_addr, wr_data}, 0);
    chk("reset_st", {st_c, st_n, st_s, st_w, st_e, st_th}, 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      run_frame(tbl[i]);
      repeat (3) tick();
    end

    // Reset in the middle of a frame
    push_frame();
    stall_cfg = 0;
    res_dly   = 0;
    exp_th    = 8'h44;
    th        = 8'h44;
    done_cnt  = 0;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    while (cyc < t0 + 20) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mid_rst_ctl", {busy, done, rd_en, st_valid, wr_en}, 0);
    chk("mid_rst_addr", {rd_addr, wr_addr, wr_data}, 0);
    chk("mid_rst_st", {st_c, st_n, st_s, st_w, st_e, st_th}, 0);
    rdq.delete(); wrq.delete(); cq.delete();
    prev_sv = 1'b0;
    repeat (12) tick();
    chk("mid_rst_nodone", done_cnt, 0);

    run_frame('{stall: 0, dly: 0, th: 8'h5a, poke: 0, spur: 0, exp_done: 73});

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
